// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, pairs 1-cycle-latency memory data with its PC,
// and presents it to decode over valid/ready with stall and redirect handling.
module fetch_unit #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [63:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_target,
  input  logic        id_ready,
  output logic        if_valid,
  output logic [63:0] if_pc,
  output logic [31:0] if_instr,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {StBoot, StRun, StHold} state_e;

  localparam logic [63:0] Step = 64'(PC_STEP);

  state_e      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [63:0] req_pc_q, req_pc_d;
  logic        req_valid_q, req_valid_d;
  logic [31:0] hold_q, hold_d;
  logic [31:0] fetch_count_q, fetch_count_d;
  logic        accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StBoot;
      pc_q          <= RESET_PC;
      req_pc_q      <= '0;
      req_valid_q   <= 1'b0;
      hold_q        <= '0;
      fetch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      req_pc_q      <= req_pc_d;
      req_valid_q   <= req_valid_d;
      hold_q        <= hold_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  // Output decode; a pending redirect kills whatever is on the wrong path.
  always_comb begin
    if_valid = 1'b0;
    if_pc    = req_pc_q;
    if_instr = '0;
    unique case (state_q)
      StBoot: begin
        if_valid = 1'b0;
      end
      StRun: begin
        if_valid = req_valid_q & ~redirect_valid;
        if_instr = imem_instr;
      end
      StHold: begin
        if_valid = ~redirect_valid;
        if_instr = hold_q;
      end
      default: begin
        if_valid = 1'b0;
      end
    endcase
  end

  assign accept = if_valid & id_ready;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    req_pc_d      = req_pc_q;
    req_valid_d   = req_valid_q;
    hold_d        = hold_q;
    fetch_count_d = fetch_count_q + {31'd0, accept};

    if (redirect_valid) begin
      pc_d        = redirect_target & ~64'h3;
      req_valid_d = 1'b0;
      state_d     = StRun;
    end else begin
      unique case (state_q)
        StBoot: begin
          req_pc_d    = pc_q;
          req_valid_d = 1'b1;
          pc_d        = pc_q + Step;
          state_d     = StRun;
        end
        StRun: begin
          if (!req_valid_q || id_ready) begin
            req_pc_d    = pc_q;
            req_valid_d = 1'b1;
            pc_d        = pc_q + Step;
          end else begin
            // Memory keeps reading pc_q, so the next word is ready when the stall ends.
            hold_d  = imem_instr;
            state_d = StHold;
          end
        end
        StHold: begin
          if (id_ready) begin
            req_pc_d = pc_q;
            pc_d     = pc_q + Step;
            state_d  = StRun;
          end
        end
        default: begin
          state_d = StBoot;
        end
      endcase
    end
  end

  assign imem_addr   = pc_q;
  assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: registered instruction memory model plus a scoreboard of
// expected (pc, instr) pairs popped whenever decode accepts.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] imem_addr;
  logic [31:0] imem_instr = '0;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_target = '0;
  logic        id_ready = 1'b1;
  logic        if_valid;
  logic [63:0] if_pc;
  logic [31:0] if_instr;
  logic [31:0] fetch_count;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  fetch_unit #(
    .RESET_PC(64'h0),
    .PC_STEP (4)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .id_ready       (id_ready),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_instr       (if_instr),
    .fetch_count    (fetch_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    case (a)
      64'd0:   return 32'h0040_0013;
      64'd4:   return 32'h0020_811B;
      64'd8:   return 32'h4011_1033;
      64'd12:  return 32'h0020_8663;
      64'd16:  return 32'h0000_006F;
      default: return a[31:0] ^ 32'hA5A5_5A5A;
    endcase
  endfunction

  always @(posedge clk) imem_instr <= mem_word(imem_addr);

  task automatic push(input logic [63:0] pc);
    exp_t e;
    e.pc    = pc;
    e.instr = mem_word(pc);
    exp_q.push_back(e);
  endtask

  task automatic drive(input logic rv, input logic [63:0] tgt, input logic rdy);
    @(negedge clk);
    redirect_valid  = rv;
    redirect_target = tgt;
    id_ready        = rdy;
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    redirect_target = '0;
    id_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
  endtask

  task automatic test_reset();
    exp_t e;
    rst_n = 1'b0;
    id_ready = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if ({if_valid, if_pc, if_instr, imem_addr, fetch_count} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got valid=%b pc=%h instr=%h addr=%h cnt=%0d exp all zero",
               if_valid, if_pc, if_instr, imem_addr, fetch_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (if_valid !== 1'b0) begin
      failures++;
      $display("FAIL boot_bubble got valid=%b exp 0", if_valid);
    end
    exp_q.delete();
    push(64'd0);
    push(64'd4);
    push(64'd8);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 64'd0, 1'b1);
      checks++;
      if (if_valid !== 1'b1) begin
        failures++;
        $display("FAIL seq_valid[%0d] got=%b exp=1", i, if_valid);
      end else if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checks++;
        if (if_pc !== e.pc || if_instr !== e.instr) begin
          failures++;
          $display("FAIL seq_data[%0d] got pc=%h instr=%h exp pc=%h instr=%h",
                   i, if_pc, if_instr, e.pc, e.instr);
        end
      end
    end
    drive(1'b0, 64'd0, 1'b0);
    checks++;
    if (fetch_count !== 32'd3) begin
      failures++;
      $display("FAIL seq_count got=%0d exp=3", fetch_count);
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL seq_drain got=%0d left exp=0", exp_q.size());
    end
  endtask

  task automatic test_stall();
    exp_t e;
    logic rdy [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    do_reset();
    push(64'd0);
    push(64'd4);
    push(64'd8);
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 64'd0, rdy[i]);
      checks++;
      if (rdy[i]) begin
        if (if_valid !== 1'b1) begin
          failures++;
          $display("FAIL stall_valid[%0d] got=%b exp=1", i, if_valid);
        end else if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          checks++;
          if (if_pc !== e.pc || if_instr !== e.instr) begin
            failures++;
            $display("FAIL stall_data[%0d] got pc=%h instr=%h exp pc=%h instr=%h",
                     i, if_pc, if_instr, e.pc, e.instr);
          end
        end
      end else if (if_valid !== 1'b1 || if_pc !== 64'd4 || if_instr !== 32'h0020_811B) begin
        failures++;
        $display("FAIL stall_hold[%0d] got valid=%b pc=%h instr=%h exp 1/4/0020811b",
                 i, if_valid, if_pc, if_instr);
      end
    end
    drive(1'b0, 64'd0, 1'b0);
    checks++;
    if (fetch_count !== 32'd3 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL stall_count got cnt=%0d left=%0d exp cnt=3 left=0",
               fetch_count, exp_q.size());
    end
  endtask

  task automatic test_redirect();
    exp_t e;
    do_reset();
    push(64'd0);
    push(64'd4);
    for (int i = 0; i < 3; i++) begin
      if (i == 2) push(64'd16);
      if (i == 2) begin
        drive(1'b1, 64'd16, 1'b1);
        checks++;
        if (if_valid !== 1'b0) begin
          failures++;
          $display("FAIL redir_kill got valid=%b pc=%h exp valid=0", if_valid, if_pc);
        end
        drive(1'b0, 64'd0, 1'b1);
        checks++;
        if (if_valid !== 1'b0 || imem_addr !== 64'd16) begin
          failures++;
          $display("FAIL redir_bubble got valid=%b addr=%h exp valid=0 addr=10",
                   if_valid, imem_addr);
        end
      end
      drive(1'b0, 64'd0, 1'b1);
      checks++;
      if (if_valid !== 1'b1 || exp_q.size() == 0) begin
        failures++;
        $display("FAIL redir_valid[%0d] got=%b exp=1", i, if_valid);
      end else begin
        e = exp_q.pop_front();
        checks++;
        if (if_pc !== e.pc || if_instr !== e.instr) begin
          failures++;
          $display("FAIL redir_data[%0d] got pc=%h instr=%h exp pc=%h instr=%h",
                   i, if_pc, if_instr, e.pc, e.instr);
        end
      end
    end
    drive(1'b0, 64'd0, 1'b0);
    checks++;
    if (fetch_count !== 32'd3) begin
      failures++;
      $display("FAIL redir_count got=%0d exp=3", fetch_count);
    end
  endtask

  task automatic test_redirect_align();
    drive(1'b1, 64'h13, 1'b1);
    drive(1'b0, 64'd0, 1'b1);
    checks++;
    if (if_valid !== 1'b0 || imem_addr !== 64'h10) begin
      failures++;
      $display("FAIL align_bubble got valid=%b addr=%h exp valid=0 addr=10", if_valid, imem_addr);
    end
    drive(1'b0, 64'd0, 1'b1);
    checks++;
    if (if_valid !== 1'b1 || if_pc !== 64'h10 || if_instr !== 32'h0000_006F) begin
      failures++;
      $display("FAIL align_data got valid=%b pc=%h instr=%h exp 1/10/0000006f",
               if_valid, if_pc, if_instr);
    end
  endtask

  task automatic test_reset_mid_hold();
    exp_t e;
    do_reset();
    drive(1'b0, 64'd0, 1'b1);
    drive(1'b0, 64'd0, 1'b0);
    drive(1'b0, 64'd0, 1'b0);
    checks++;
    if (if_valid !== 1'b1 || if_instr !== 32'h0020_811B || fetch_count !== 32'd1) begin
      failures++;
      $display("FAIL mid_hold_pre got valid=%b instr=%h cnt=%0d exp 1/0020811b/1",
               if_valid, if_instr, fetch_count);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({if_valid, if_pc, if_instr, imem_addr, fetch_count} !== '0) begin
      failures++;
      $display("FAIL mid_hold_reset got valid=%b pc=%h instr=%h addr=%h cnt=%0d exp all zero",
               if_valid, if_pc, if_instr, imem_addr, fetch_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    id_ready = 1'b1;
    #1;
    checks++;
    if (if_valid !== 1'b0) begin
      failures++;
      $display("FAIL mid_hold_boot got valid=%b exp 0", if_valid);
    end
    exp_q.delete();
    push(64'd0);
    push(64'd4);
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 64'd0, 1'b1);
      checks++;
      if (if_valid !== 1'b1 || exp_q.size() == 0) begin
        failures++;
        $display("FAIL restart_valid[%0d] got=%b exp=1", i, if_valid);
      end else begin
        e = exp_q.pop_front();
        checks++;
        if (if_pc !== e.pc || if_instr !== e.instr) begin
          failures++;
          $display("FAIL restart_data[%0d] got pc=%h instr=%h exp pc=%h instr=%h",
                   i, if_pc, if_instr, e.pc, e.instr);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    do_reset();
    drive(1'b0, 64'd0, 1'b1);
    // Redirect while decode stalls: must not enter HOLD with the killed word.
    drive(1'b1, 64'd8, 1'b0);
    checks++;
    if (if_valid !== 1'b0) begin
      failures++;
      $display("FAIL rs_kill got valid=%b exp 0", if_valid);
    end
    drive(1'b0, 64'd0, 1'b0);
    checks++;
    if (if_valid !== 1'b0) begin
      failures++;
      $display("FAIL rs_bubble got valid=%b pc=%h exp valid=0", if_valid, if_pc);
    end
    drive(1'b0, 64'd0, 1'b0);
    checks++;
    if (if_valid !== 1'b1 || if_pc !== 64'd8 || if_instr !== 32'h4011_1033) begin
      failures++;
      $display("FAIL rs_target got valid=%b pc=%h instr=%h exp 1/8/40111033",
               if_valid, if_pc, if_instr);
    end
    drive(1'b1, 64'd0, 1'b0);
    drive(1'b0, 64'd0, 1'b1);
    push(64'd0);
    drive(1'b1, 64'd16, 1'b1);
    drive(1'b1, 64'd4, 1'b1);
    drive(1'b0, 64'd0, 1'b1);
    checks++;
    if (if_valid !== 1'b0 || imem_addr !== 64'd4) begin
      failures++;
      $display("FAIL b2b_bubble got valid=%b addr=%h exp valid=0 addr=4", if_valid, imem_addr);
    end
    exp_q.delete();
    push(64'd4);
    push(64'd8);
    drive(1'b0, 64'd0, 1'b1);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (if_valid !== 1'b1 || exp_q.size() == 0) begin
        failures++;
        $display("FAIL b2b_valid[%0d] got=%b exp=1", i, if_valid);
      end else begin
        e = exp_q.pop_front();
        checks++;
        if (if_pc !== e.pc || if_instr !== e.instr) begin
          failures++;
          $display("FAIL b2b_data[%0d] got pc=%h instr=%h exp pc=%h instr=%h",
                   i, if_pc, if_instr, e.pc, e.instr);
        end
      end
      if (i == 0) drive(1'b0, 64'd0, 1'b1);
    end
  endtask

  task automatic test_wrap();
    exp_t e;
    drive(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    drive(1'b0, 64'd0, 1'b1);
    exp_q.delete();
    push(64'hFFFF_FFFF_FFFF_FFFC);
    push(64'd0);
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 64'd0, 1'b1);
      checks++;
      if (if_valid !== 1'b1 || exp_q.size() == 0) begin
        failures++;
        $display("FAIL wrap_valid[%0d] got=%b exp=1", i, if_valid);
      end else begin
        e = exp_q.pop_front();
        checks++;
        if (if_pc !== e.pc || if_instr !== e.instr) begin
          failures++;
          $display("FAIL wrap_data[%0d] got pc=%h instr=%h exp pc=%h instr=%h",
                   i, if_pc, if_instr, e.pc, e.instr);
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL wrap_drain got=%0d left exp=0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_stall();
    test_redirect();
    test_redirect_align();
    test_reset_mid_hold();
    test_back_to_back();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
